// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
//   It merges stall requests from ID (load-use), EX (multi-cycle divider) and
//   MEM (data SRAM wait) into one stall bus. The bus freezes the PC and the
//   inter-stage registers. The block also extends load-use bubbles, tells ID to
//   hold its captured instruction, and keeps stall counters and a watchdog.
//
//   Request semantics: the stallreq_* inputs are level signals. A request is
//   honoured in the same cycle it is seen, through the combinational stall
//   output. There is no handshake; a source keeps its request high for as
//   long as it needs the pipeline frozen.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous, active-high reset
//   stallreq_id    in   load-use hazard request from ID (combinational in ID)
//   stallreq_ex    in   EX multi-cycle unit busy
//   stallreq_mem   in   MEM data SRAM not ready
//   stall[5:0]     out  stall bus: bit0 PC, bit1 IF/ID, bit2 ID/EX,
//                       bit3 EX/MEM, bit4 MEM/WB, bit5 WB (never set); 1 = stop
//   id_inst_hold   out  registered; ID uses its captured instruction
//   ctrl_state     out  current FSM state (debug)
//   stall_cycles   out  count of cycles with stall[0]=1 (wraps)
//   load_use_cnt   out  count of accepted load-use events
//   stall_timeout  out  sticky watchdog flag
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
   parameter int LOAD_BUBBLE = 1,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   output logic [5:0]       stall,
   output logic             id_inst_hold,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic             stall_timeout
);

   localparam logic [5:0] L_NONE = 6'b000000;
   localparam logic [5:0] L_ID   = 6'b000111;
   localparam logic [5:0] L_EX   = 6'b001111;
   localparam logic [5:0] L_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      LU   = 2'd1,
      EXW  = 2'd2,
      MEMW = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  bub_cnt, bub_nxt;
   logic [15:0] wd_cnt;
   logic [5:0]  req_level;
   logic [5:0]  held_level;
   logic        id_only;
   logic        id_only_q;

   // Request-derived level, with mem winning over ex, and ex winning over id.
   always_comb begin
      req_level = L_NONE;
      if (stallreq_mem)      req_level = L_MEM;
      else if (stallreq_ex)  req_level = L_EX;
      else if (stallreq_id)  req_level = L_ID;
   end

   // Only the extended load-use bubble holds a level of its own.
   // EXW and MEMW follow the live requests.
   always_comb begin
      held_level = L_NONE;
      if (state == LU && bub_cnt != 4'd0) held_level = L_ID;
   end

   // The levels are nested masks, so OR-ing them selects the highest one.
   always_comb begin
      stall = L_NONE;
      if (!rst) stall = req_level | held_level;
   end

   // A load-use request counts only if it wins arbitration while in RUN.
   assign id_only    = (state == RUN) && stallreq_id && !stallreq_ex && !stallreq_mem;
   assign ctrl_state = state;

   always_comb begin
      state_nxt = state;
      bub_nxt   = bub_cnt;
      case (state)
         RUN: begin
            if (stallreq_mem) begin
               state_nxt = MEMW;
            end else if (stallreq_ex) begin
               state_nxt = EXW;
            end else if (stallreq_id && (LOAD_BUBBLE > 1)) begin
               state_nxt = LU;
               bub_nxt   = 4'(LOAD_BUBBLE - 1);
            end
         end
         LU: begin
            if (stallreq_mem) begin
               state_nxt = MEMW;
               bub_nxt   = 4'd0;
            end else if (stallreq_ex) begin
               state_nxt = EXW;
               bub_nxt   = 4'd0;
            end else if (bub_cnt <= 4'd1) begin
               state_nxt = RUN;
               bub_nxt   = 4'd0;
            end else begin
               bub_nxt   = bub_cnt - 4'd1;
            end
         end
         EXW: begin
            if (stallreq_mem)      state_nxt = MEMW;
            else if (stallreq_ex)  state_nxt = EXW;
            else                   state_nxt = RUN;
         end
         MEMW: begin
            if (stallreq_mem)      state_nxt = MEMW;
            else if (stallreq_ex)  state_nxt = EXW;
            else                   state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
            bub_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         bub_cnt       <= 4'd0;
         wd_cnt        <= 16'd0;
         stall_cycles  <= '0;
         load_use_cnt  <= '0;
         stall_timeout <= 1'b0;
         id_inst_hold  <= 1'b0;
         id_only_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         bub_cnt   <= bub_nxt;
         id_only_q <= id_only;

         if (stall[0]) stall_cycles <= stall_cycles + CNT_W'(1);

         // A held load-use request counts once, on its rising edge.
         if (id_only && !id_only_q) load_use_cnt <= load_use_cnt + CNT_W'(1);

         // The watchdog counts consecutive stalled cycles and saturates at
         // TIMEOUT. It only reports; it never changes the stall bus.
         if (!stall[0])                          wd_cnt <= 16'd0;
         else if (wd_cnt < 16'(TIMEOUT))         wd_cnt <= wd_cnt + 16'd1;

         if (stall[0] && wd_cnt == 16'(TIMEOUT - 1)) stall_timeout <= 1'b1;

         id_inst_hold <= stall[1] & stall[2];
      end
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It collects stall requests from three sources: the ID load-use hazard, the EX multi-cycle unit (divider) and the MEM data-SRAM wait. It drives the shared stall bus that freezes the PC and the inter-stage registers. It also gives ID an instruction-hold indication, keeps stall performance counters and runs a stall watchdog.

Parameters:
LOAD_BUBBLE, 1, minimum number of ID-level stall cycles inserted per load-use request (1..15)
TIMEOUT, 64, consecutive stalled cycles after which the watchdog trips (2..2^16-1)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
stallreq_id  in  1  load-use hazard request from ID (combinational in ID)
stallreq_ex  in  1  EX multi-cycle unit busy
stallreq_mem  in  1  MEM data SRAM not ready
stall  out  6  stall bus (`StallBus); bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = `Stop
id_inst_hold  out  1  registered; ID must use its captured instruction, not inst_sram_rdata
ctrl_state  out  2  current FSM state (debug)
stall_cycles  out  CNT_W  cycles with stall[0]=1
load_use_cnt  out  CNT_W  number of load-use events accepted
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Stall levels:
  - L_ID = 6'b000111
  - L_EX = 6'b001111
  - L_MEM = 6'b011111
  - none = 6'b000000
  - bit5 is never asserted.
- stall is combinational, with the same-cycle response to requests required. It is the highest of:
  - the request-derived level (mem > ex > id)
  - the FSM-held level
- While rst=1, stall = 0.
- FSM states:
  - RUN = 0
  - LU = 1 (extended load-use bubble)
  - EXW = 2
  - MEMW = 3
- Transitions out of RUN, in priority order:
  - stallreq_mem -> MEMW
  - else stallreq_ex -> EXW
  - else stallreq_id and LOAD_BUBBLE>1 -> LU, with bub_cnt <= LOAD_BUBBLE-1
  - LOAD_BUBBLE=1: stay in RUN; the bubble is the combinational request only.
- LU:
  - Held level is L_ID while bub_cnt != 0; bub_cnt decrements each cycle.
  - Go to RUN when bub_cnt reaches 1 and no other request is present.
  - stallreq_mem/stallreq_ex in LU -> MEMW/EXW; the bubble counter is abandoned (cleared).
- EXW:
  - Stay while stallreq_ex=1.
  - stallreq_mem -> MEMW.
  - Request drops -> RUN. stall follows the combinational requests that cycle, so no extra cycle is inserted.
- MEMW:
  - Stay while stallreq_mem=1; drop -> RUN.
  - An EX request pending at drop -> EXW.
- EXW and MEMW hold no level of their own; they track state for counters and debug.
- load_use_cnt:
  - Increments by 1 on each cycle where stallreq_id=1 in RUN with no higher request.
  - Consecutive cycles of the same request count once: edge-detect the request using a registered copy of the previous cycle's ID-only condition.
- stall_cycles: increments each cycle stall[0]=1; wraps modulo 2^CNT_W.
- Watchdog:
  - wd_cnt (16 bit) increments while stall[0]=1, saturates at TIMEOUT, clears to 0 on any cycle with stall[0]=0.
  - stall_timeout sets when wd_cnt == TIMEOUT-1 and stall[0]=1. It remains 1 until rst.
  - The watchdog never alters stall.
- id_inst_hold <= stall[1] & stall[2] every cycle.
  - It is 1 in the cycle following any cycle in which IF/ID and ID/EX were both frozen, otherwise 0.
  - After an L_ID/L_EX/L_MEM stall ends, it is 1 for exactly one cycle.
- Reset (also mid-stall):
  - Next edge: state=RUN, bub_cnt=0, wd_cnt=0, counters=0, id_inst_hold=0, stall_timeout=0, ctrl_state=0.
  - Requests sampled during rst are ignored.
- Simultaneous requests: the highest level wins. Only the winning event advances the FSM. load_use_cnt does not count an id request masked by ex/mem.

Test Plan:
1. Reset, no requests for 10 cycles -> stall=000000, id_inst_hold=0, all counters 0, ctrl_state=0.
2. LOAD_BUBBLE=1: stallreq_id pulse 1 cycle -> stall=000111 that same cycle; next cycle stall=0 and id_inst_hold=1; load_use_cnt=1, stall_cycles=1.
3. LOAD_BUBBLE=3: stallreq_id 1 cycle -> stall=000111 for 3 consecutive cycles, ctrl_state=1 for cycles 2-3, then RUN; load_use_cnt=1, stall_cycles=3.
4. stallreq_ex high 5 cycles with stallreq_id high in cycles 2-3 -> stall=001111 for 5 cycles, ctrl_state=2, load_use_cnt stays 0; stallreq_mem in cycle 4 -> stall=011111, ctrl_state=3 next cycle.
5. TIMEOUT=8: stallreq_mem held 10 cycles -> stall_timeout rises at end of 8th stalled cycle, stays 1 after request drops; stall_cycles=10.
6. rst asserted during MEMW with stallreq_mem still high -> stall=0 during rst; after release ctrl_state=0, stall_timeout=0, counters=0; stall re-asserts 011111 combinationally in the first post-reset cycle.
